// File: rtl/trace_pkg.sv
// Shared definitions for the instruction-trace controller: FSM encoding,
// default parameter values and a saturating counter helper.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam int unsigned DEF_PC_W        = 32;
  localparam int unsigned DEF_IR_W        = 32;
  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_RST_CYCLES  = 4;
  localparam int unsigned DEF_HALT_REPEAT = 4;
  localparam int unsigned DEF_TIMEOUT     = 4096;
  localparam int unsigned DEF_MODE        = 1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace buffer: DEPTH-entry FIFO with wrap-around pointers, registered
// read data (latency 1), sticky overflow on dropped writes.
module trace_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] wr_data,
  input  logic         wr_en,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         pop, push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign push  = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop) begin
        rptr    <= rptr + (AW+1)'(1);
        rd_data <= mem[rptr[AW-1:0]];
      end
      rd_valid <= pop;
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/trace_ctrl.sv
// Core run controller: holds the core in reset, then logs fetches into the
// trace buffer until a halt (repeated PC) or run-cycle timeout.
module trace_ctrl
  import trace_pkg::*;
#(
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned IR_W        = DEF_IR_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned MODE        = DEF_MODE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_i,
  input  logic [IR_W-1:0] ir_i,
  input  logic            valid_i,
  input  logic            rd_en_i,
  output logic            cpu_rst_o,
  output logic [PC_W-1:0] rd_pc_o,
  output logic [IR_W-1:0] rd_ir_o,
  output logic            rd_valid_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            overflow_o,
  output logic            halted_o,
  output logic            timeout_o,
  output logic [31:0]     cycle_cnt_o,
  output logic [31:0]     instr_cnt_o,
  output logic [1:0]      state_o
);

  state_t            state, state_nxt;
  logic [31:0]       hold_cnt;
  logic [31:0]       cycle_cnt, instr_cnt, same_cnt;
  logic [PC_W-1:0]   last_pc;
  logic [IR_W-1:0]   last_ir;
  logic              have_last;
  logic              halted, timeout;

  logic              run_fetch, changed, wr_en;
  logic              halt_hit, tmo_hit;
  logic [31:0]       same_nxt, cyc_nxt;
  logic [PC_W+IR_W-1:0] rd_data;

  always_comb begin
    run_fetch = (state == ST_RUN) && valid_i;
    same_nxt  = (have_last && (pc_i == last_pc)) ? sat_inc(same_cnt) : 32'd1;
    cyc_nxt   = sat_inc(cycle_cnt);
    halt_hit  = run_fetch && (same_nxt >= 32'(HALT_REPEAT));
    tmo_hit   = (state == ST_RUN) && (cyc_nxt == 32'(TIMEOUT));
    changed   = !have_last || (pc_i != last_pc) || (ir_i != last_ir);
    wr_en     = run_fetch && ((MODE == 0) || changed);
  end

  always_comb begin
    state_nxt = state;
    cpu_rst_o = 1'b0;
    case (state)
      ST_HOLD: begin
        cpu_rst_o = 1'b1;
        if (hold_cnt == 32'(RST_CYCLES - 1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Halt takes priority over a coincident timeout.
        if (halt_hit)     state_nxt = ST_HALTED;
        else if (tmo_hit) state_nxt = ST_TIMEOUT;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      same_cnt  <= '0;
      last_pc   <= '0;
      last_ir   <= '0;
      have_last <= 1'b0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_HOLD) hold_cnt <= hold_cnt + 32'd1;
      if (state == ST_RUN) begin
        cycle_cnt <= cyc_nxt;
        if (valid_i) begin
          instr_cnt <= sat_inc(instr_cnt);
          same_cnt  <= same_nxt;
          last_pc   <= pc_i;
          last_ir   <= ir_i;
          have_last <= 1'b1;
        end
      end
      if (halt_hit)     halted  <= 1'b1;
      else if (tmo_hit) timeout <= 1'b1;
    end
  end

  trace_fifo #(
    .W     (PC_W + IR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  ({pc_i, ir_i}),
    .wr_en    (wr_en),
    .rd_en    (rd_en_i),
    .rd_data  (rd_data),
    .rd_valid (rd_valid_o),
    .empty    (empty_o),
    .full     (full_o),
    .overflow (overflow_o)
  );

  assign rd_pc_o     = rd_data[PC_W+IR_W-1:IR_W];
  assign rd_ir_o     = rd_data[IR_W-1:0];
  assign halted_o    = halted;
  assign timeout_o   = timeout;
  assign cycle_cnt_o = cycle_cnt;
  assign instr_cnt_o = instr_cnt;
  assign state_o     = state;

endmodule

// File: tb/tb_trace_ctrl.sv
// Bench for trace_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized runs.
module tb_trace_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned RSTC  = 4;
  localparam int unsigned HREP  = 4;
  localparam int unsigned TMO   = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0, ir = '0;
  logic        valid = 1'b0, rd_en = 1'b0;
  logic        cpu_rst_o, rd_valid_o, empty_o, full_o, overflow_o, halted_o, timeout_o;
  logic [31:0] rd_pc_o, rd_ir_o, cycle_cnt_o, instr_cnt_o;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  trace_ctrl #(
    .PC_W(32), .IR_W(32), .DEPTH(DEPTH), .RST_CYCLES(RSTC),
    .HALT_REPEAT(HREP), .TIMEOUT(TMO), .MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .pc_i(pc), .ir_i(ir), .valid_i(valid), .rd_en_i(rd_en),
    .cpu_rst_o(cpu_rst_o), .rd_pc_o(rd_pc_o), .rd_ir_o(rd_ir_o), .rd_valid_o(rd_valid_o),
    .empty_o(empty_o), .full_o(full_o), .overflow_o(overflow_o),
    .halted_o(halted_o), .timeout_o(timeout_o),
    .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: states as plain integers, buffer as a queue.
  int          m_state, m_hold, m_same;
  logic [31:0] m_cyc, m_ins, m_lpc, m_lir, m_rpc, m_rir;
  bit          m_have, m_ovf, m_halt, m_tmo, m_rdv;
  logic [63:0] q[$];

  always @(posedge clk) begin
    bit          pop, push;
    logic [63:0] e;
    if (rst) begin
      m_state = 0; m_hold = 0; m_same = 0;
      m_cyc = 0; m_ins = 0; m_lpc = 0; m_lir = 0; m_rpc = 0; m_rir = 0;
      m_have = 0; m_ovf = 0; m_halt = 0; m_tmo = 0; m_rdv = 0;
      q.delete();
    end else begin
      pop  = rd_en && (q.size() != 0);
      push = 0;
      if (m_state == 0) begin
        m_hold++;
        if (m_hold == RSTC) m_state = 1;
      end else if (m_state == 1) begin
        if (m_cyc != 32'hffff_ffff) m_cyc++;
        if (valid) begin
          if (m_ins != 32'hffff_ffff) m_ins++;
          m_same = (m_have && pc == m_lpc) ? m_same + 1 : 1;
          push   = !m_have || pc != m_lpc || ir != m_lir;
          m_lpc = pc; m_lir = ir; m_have = 1;
        end
        if (valid && m_same >= HREP) begin m_state = 2; m_halt = 1; end
        else if (m_cyc == TMO)       begin m_state = 3; m_tmo  = 1; end
      end
      if (pop) begin
        e = q.pop_front();
        m_rdv = 1; m_rpc = e[63:32]; m_rir = e[31:0];
      end else m_rdv = 0;
      if (push) begin
        if (q.size() < DEPTH) q.push_back({pc, ir});
        else m_ovf = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",     state_o,     m_state);
      chk("cpu_rst",   cpu_rst_o,   m_state == 0);
      chk("empty",     empty_o,     q.size() == 0);
      chk("full",      full_o,      q.size() == DEPTH);
      chk("overflow",  overflow_o,  m_ovf);
      chk("halted",    halted_o,    m_halt);
      chk("timeout",   timeout_o,   m_tmo);
      chk("cycle_cnt", cycle_cnt_o, m_cyc);
      chk("instr_cnt", instr_cnt_o, m_ins);
      chk("rd_valid",  rd_valid_o,  m_rdv);
      chk("rd_pc",     rd_pc_o,     m_rpc);
      chk("rd_ir",     rd_ir_o,     m_rir);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; valid = 0; rd_en = 0;
    cyc();
    rst = 0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < int'(RSTC); i++) begin
      chk("cpu_rst_hold", cpu_rst_o, 1);
      cyc();
    end
    chk("run_entry", state_o, 1);
    chk("cpu_rst_run", cpu_rst_o, 0);
  endtask

  task automatic fetch(input logic [31:0] p, input logic [31:0] i);
    valid = 1; pc = p; ir = i;
    cyc();
    valid = 0;
  endtask

  task automatic pop_expect(input string nm, input bit v, input logic [31:0] p);
    rd_en = 1;
    cyc();
    rd_en = 0;
    chk({nm, "_v"}, rd_valid_o, v);
    if (v) chk({nm, "_pc"}, rd_pc_o, p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk_en = 1;
    chk("rst_empty", empty_o, 1);
    chk("rst_rdv", rd_valid_o, 0);
    chk("rst_cnt", cycle_cnt_o, 0);
    wait_run();

    // Repeated identical fetch is not logged in change-only mode
    fetch(32'h0, 32'h2008_0001);
    fetch(32'h0, 32'h2008_0001);
    fetch(32'h4, 32'h0109_4820);
    chk("model_two_entries", q.size(), 2);
    pop_expect("pop0", 1, 32'h0);
    chk("pop0_ir", rd_ir_o, 32'h2008_0001);
    pop_expect("pop1", 1, 32'h4);
    chk("pop1_ir", rd_ir_o, 32'h0109_4820);
    pop_expect("pop_empty", 0, 0);

    // Overflow: 17 distinct fetches into 16 slots
    do_reset(); wait_run();
    for (int i = 0; i < 17; i++) fetch(32'(i * 4), 32'h1000 + 32'(i));
    chk("ovf_full", full_o, 1);
    chk("ovf_flag", overflow_o, 1);
    for (int i = 0; i < 16; i++) pop_expect("ovf_pop", 1, 32'(i * 4));
    pop_expect("ovf_17th", 0, 0);
    chk("ovf_empty", empty_o, 1);

    // Halt on repeated PC
    do_reset(); wait_run();
    for (int i = 0; i < 4; i++) fetch(32'h10, 32'hdead_0001);
    chk("halt_flag", halted_o, 1);
    chk("halt_state", state_o, 2);
    chk("halt_instr", instr_cnt_o, 4);
    for (int i = 0; i < 3; i++) fetch(32'h20 + 32'(i * 4), 32'h55);
    chk("halt_frozen", instr_cnt_o, 4);
    pop_expect("halt_pop", 1, 32'h10);
    pop_expect("halt_nomore", 0, 0);

    // Timeout with no halt
    do_reset(); wait_run();
    begin
      int k = 0;
      while (state_o != 2'd3 && k < 200) begin cyc(); k++; end
    end
    chk("tmo_state", state_o, 3);
    chk("tmo_flag", timeout_o, 1);
    chk("tmo_cycles", cycle_cnt_o, 100);
    for (int i = 0; i < 5; i++) fetch(32'h80 + 32'(i * 4), 32'h1);
    chk("tmo_frozen_cyc", cycle_cnt_o, 100);
    chk("tmo_frozen_ins", instr_cnt_o, 0);
    chk("tmo_no_write", empty_o, 1);

    // Simultaneous push and pop while full, then mid-run reset
    do_reset(); wait_run();
    for (int i = 0; i < 16; i++) fetch(32'h100 + 32'(i * 4), 32'h77);
    chk("pp_full", full_o, 1);
    valid = 1; pc = 32'h400; ir = 32'h99; rd_en = 1;
    cyc();
    valid = 0; rd_en = 0;
    chk("pp_ovf", overflow_o, 0);
    chk("pp_still_full", full_o, 1);
    chk("pp_pop", rd_pc_o, 32'h100);
    rst = 1;
    cyc();
    rst = 0;
    chk("midrst_empty", empty_o, 1);
    chk("midrst_state", state_o, 0);

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      int unsigned pcmax = (r % 3 == 0) ? 1 : ((r % 3 == 1) ? 3 : 15);
      do_reset();
      for (int c = 0; c < 160; c++) begin
        rst   = ($urandom_range(0, 199) == 0);
        valid = $urandom_range(0, 3) != 0;
        pc    = 32'($urandom_range(0, pcmax)) * 4;
        ir    = 32'($urandom_range(0, 2));
        rd_en = $urandom_range(0, 3) == 0;
        cyc();
      end
      rst = 0; valid = 0; rd_en = 0;
      for (int c = 0; c < 20; c++) begin
        rd_en = 1;
        cyc();
      end
      rd_en = 0;
    end

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
